// File: rtl/ir_pkg.sv
// Shared types and the per-colour timing table for the IR car-remote transmitter.
// All lengths are in carrier cycles.
package ir_pkg;

    localparam int BURST_WIDTH = 8;

    localparam logic [7:0] REG_CMD  = 8'd0;
    localparam logic [7:0] REG_CAR  = 8'd1;
    localparam logic [7:0] REG_CTRL = 8'd2;

    typedef enum logic [1:0] {
        CAR_BLUE,
        CAR_YELLOW,
        CAR_GREEN,
        CAR_RED
    } car_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_CARSEL,
        S_BIT
    } state_e;

    typedef logic [BURST_WIDTH-1:0] burst_t;

    typedef struct packed {
        burst_t start_len;
        burst_t carsel_len;
        burst_t gap_len;
        burst_t one_len;
        burst_t zero_len;
    } timing_t;

    localparam timing_t TIMING [4] = '{
        '{8'd191, 8'd47, 8'd25, 8'd47, 8'd22},
        '{8'd88,  8'd22, 8'd40, 8'd44, 8'd22},
        '{8'd88,  8'd44, 8'd40, 8'd44, 8'd22},
        '{8'd192, 8'd24, 8'd24, 8'd48, 8'd24}
    };

endpackage

// File: rtl/ir_tick_gen.sv
// Clock-enable divider: one-cycle pulse every DIV clocks, free-running from reset.
module ir_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/ir_transmitter_multi.sv
// Bus-mapped IR car-remote transmitter with run-time colour select,
// periodic or one-shot packets and a BUSY status.
module ir_transmitter_multi
    import ir_pkg::*;
#(
    parameter logic [7:0] IO_ADDRESS  = 8'h90,
    parameter int         IN_MHZ      = 100,
    parameter int         CARRIER_KHZ = 40,
    parameter int         PACKET_HZ   = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BUS_WE,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    output logic       IR_LED,
    output logic       BUSY,
    output logic [1:0] CAR_SEL
);

    localparam int HALF    = IN_MHZ * 1000 / (2 * CARRIER_KHZ);
    localparam int PKT_DIV = IN_MHZ * 1000000 / PACKET_HZ;
    localparam logic [2:0] SEQ_LAST = 3'd6;

    logic half_tick, pkt_tick;

    ir_tick_gen #(.DIV(HALF)) u_half (
        .clk (CLK),
        .rst (RESET),
        .tick(half_tick)
    );

    ir_tick_gen #(.DIV(PKT_DIV)) u_pkt (
        .clk (CLK),
        .rst (RESET),
        .tick(pkt_tick)
    );

    logic       wr_cmd, wr_car, wr_ctrl, send_now;
    logic [3:0] cmd_q;
    car_e       car_q;
    logic       periodic_q;
    logic       req_q;
    logic       unused_bits;

    assign wr_cmd      = BUS_WE && (BUS_ADDR == IO_ADDRESS + REG_CMD);
    assign wr_car      = BUS_WE && (BUS_ADDR == IO_ADDRESS + REG_CAR);
    assign wr_ctrl     = BUS_WE && (BUS_ADDR == IO_ADDRESS + REG_CTRL);
    assign send_now    = wr_ctrl && BUS_DATA[1];
    assign unused_bits = ^BUS_DATA[7:4];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cmd_q      <= '0;
            car_q      <= CAR_YELLOW;
            periodic_q <= 1'b0;
        end else begin
            unique case (1'b1)
                wr_cmd:  cmd_q      <= BUS_DATA[3:0];
                wr_car:  car_q      <= car_e'(BUS_DATA[1:0]);
                wr_ctrl: periodic_q <= BUS_DATA[0];
                default: ;
            endcase
        end
    end

    state_e     state_q, state_d;
    burst_t     cnt_q, cnt_d;
    logic [2:0] seq_q, seq_d;
    logic [3:0] cmd_s;
    timing_t    tm_s;
    logic       phase_q;
    logic       carrier_rise, last, leave_idle;
    logic [1:0] bit_idx;

    assign carrier_rise = half_tick && !phase_q;
    assign last         = (cnt_q == burst_t'(1));
    assign bit_idx      = 2'(seq_q - 3'd2);

    // Ticks are only honoured in IDLE; SEND_NOW is remembered at any time.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase_q <= 1'b0;
            req_q   <= 1'b0;
            cmd_s   <= '0;
            tm_s    <= '0;
        end else begin
            if (half_tick) phase_q <= !phase_q;
            if (pkt_tick && periodic_q && state_q == S_IDLE) req_q <= 1'b1;
            if (leave_idle) req_q <= 1'b0;
            if (send_now) req_q <= 1'b1;
            if (leave_idle) begin
                cmd_s <= cmd_q;
                tm_s  <= TIMING[car_q];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        leave_idle = 1'b0;
        if (carrier_rise) begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_q) begin
                        leave_idle = 1'b1;
                        state_d    = S_START;
                        cnt_d      = TIMING[car_q].start_len;
                        seq_d      = '0;
                    end
                end
                S_START, S_CARSEL, S_BIT: begin
                    if (last) begin
                        state_d = S_GAP;
                        cnt_d   = tm_s.gap_len;
                        seq_d   = seq_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q - burst_t'(1);
                    end
                end
                S_GAP: begin
                    if (!last) begin
                        cnt_d = cnt_q - burst_t'(1);
                    end else if (seq_q == 3'd1) begin
                        state_d = S_CARSEL;
                        cnt_d   = tm_s.carsel_len;
                    end else if (seq_q == SEQ_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_BIT;
                        cnt_d   = cmd_s[bit_idx] ? tm_s.one_len : tm_s.zero_len;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign IR_LED  = phase_q &&
                     (state_q == S_START || state_q == S_CARSEL || state_q == S_BIT);
    assign BUSY    = (state_q != S_IDLE);
    assign CAR_SEL = car_q;

endmodule

// File: tb/tb_ir_transmitter_multi.sv
// Directed bench for ir_transmitter_multi: burst lengths, gaps, BUSY window,
// periodic drop, snapshotting, pending SEND_NOW, async reset, address decode.
module tb_ir_transmitter_multi;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BUS_WE = 1'b0;
    logic [7:0] BUS_ADDR = 8'h00;
    logic [7:0] BUS_DATA = 8'h00;
    logic       IR_LED, BUSY;
    logic [1:0] CAR_SEL;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int led_rise[$];
    int busy_rise[$];
    int busy_fall[$];
    int bstart[$];
    int bcnt[$];
    logic led_p = 1'b0;
    logic busy_p = 1'b0;

    int e1[6]  = '{88, 22, 22, 44, 22, 44};
    int e3a[6] = '{191, 47, 47, 22, 47, 22};
    int e3b[6] = '{88, 44, 44, 44, 44, 44};
    int e6[6]  = '{88, 22, 22, 22, 22, 22};

    ir_transmitter_multi #(
        .IO_ADDRESS (8'h90),
        .IN_MHZ     (1),
        .CARRIER_KHZ(100),
        .PACKET_HZ  (1000)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .BUS_WE  (BUS_WE),
        .BUS_ADDR(BUS_ADDR),
        .BUS_DATA(BUS_DATA),
        .IR_LED  (IR_LED),
        .BUSY    (BUSY),
        .CAR_SEL (CAR_SEL)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        if (IR_LED && !led_p) led_rise.push_back(cyc);
        if (BUSY && !busy_p) busy_rise.push_back(cyc);
        if (!BUSY && busy_p) busy_fall.push_back(cyc);
        led_p <= IR_LED;
        busy_p <= BUSY;
    end

    task automatic chk(string tag, int got, int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int qat(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        led_rise.delete();
        busy_rise.delete();
        busy_fall.delete();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        clear_logs();
        RESET = 1'b0;
    endtask

    task automatic wr(logic [7:0] a, logic [7:0] d);
        @(negedge CLK);
        BUS_WE = 1'b1;
        BUS_ADDR = a;
        BUS_DATA = d;
        @(negedge CLK);
        BUS_WE = 1'b0;
    endtask

    task automatic wait_busy(logic lvl, int limit, string tag);
        int n = 0;
        while (BUSY !== lvl && n < limit) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, int'(BUSY), int'(lvl));
    endtask

    task automatic split();
        bstart.delete();
        bcnt.delete();
        foreach (led_rise[i]) begin
            if (i == 0 || led_rise[i] - led_rise[i-1] > 10) begin
                bstart.push_back(led_rise[i]);
                bcnt.push_back(1);
            end else begin
                bcnt[bcnt.size()-1] = bcnt[bcnt.size()-1] + 1;
            end
        end
    endtask

    task automatic chk_pkt(string tag, int b, int exp_n[6], int gap);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s_len%0d", tag, k), qat(bcnt, b + k), exp_n[k]);
            if (k > 0) begin
                chk($sformatf("%s_pitch%0d", tag, k),
                    (b + k < bstart.size()) ? bstart[b+k] - bstart[b+k-1] : -1,
                    (exp_n[k-1] + gap) * 10);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        logic pre;

        // 1: one-shot yellow packet, COMMAND=1010
        do_reset();
        chk("rst_led", int'(IR_LED), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_car", int'(CAR_SEL), 1);
        wr(8'h91, 8'h01);
        wr(8'h90, 8'h0A);
        wr(8'h92, 8'h02);
        wait_busy(1'b1, 100, "t1_start");
        wait_busy(1'b0, 6000, "t1_end");
        repeat (3000) @(negedge CLK);
        split();
        chk("t1_bursts", bcnt.size(), 6);
        chk_pkt("t1", 0, e1, 40);
        chk("t1_pkts", busy_rise.size(), 1);
        chk("t1_busy_len", qat(busy_fall, 0) - qat(busy_rise, 0), 4820);
        chk("t1_align", qat(busy_rise, 0) - qat(led_rise, 0), 0);

        // 2: periodic red, START outlasts a tick period
        do_reset();
        wr(8'h91, 8'h03);
        wr(8'h90, 8'h00);
        wr(8'h92, 8'h01);
        repeat (12000) @(negedge CLK);
        split();
        r0 = qat(busy_rise, 0);
        chk("t2_pkts", busy_rise.size(), 3);
        chk("t2_near_tick", int'((r0 % 1000) >= 1 && (r0 % 1000) <= 10), 1);
        chk("t2_period", qat(busy_rise, 1) - r0, 5000);
        chk("t2_start_len", qat(bcnt, 0), 192);
        chk("t2_carsel_len", qat(bcnt, 1), 24);
        chk("t2_pitch", qat(bstart, 1) - qat(bstart, 0), 2160);
        chk("t2_busy_len", qat(busy_fall, 0) - r0, 4560);

        // 3+4: writes mid-packet, triple SEND_NOW -> one back-to-back packet
        do_reset();
        wr(8'h91, 8'h00);
        wr(8'h90, 8'h05);
        wr(8'h92, 8'h02);
        wait_busy(1'b1, 100, "t3_start");
        repeat (100) @(negedge CLK);
        wr(8'h90, 8'h0F);
        wr(8'h91, 8'h02);
        wr(8'h92, 8'h02);
        wr(8'h92, 8'h02);
        wr(8'h92, 8'h02);
        chk("t3_carsel", int'(CAR_SEL), 2);
        wait_busy(1'b0, 8000, "t3_end1");
        wait_busy(1'b1, 100, "t3_start2");
        wait_busy(1'b0, 8000, "t3_end2");
        repeat (3000) @(negedge CLK);
        split();
        chk("t3_bursts", bcnt.size(), 12);
        chk_pkt("t3a", 0, e3a, 25);
        chk_pkt("t3b", 6, e3b, 40);
        chk("t3_pkts", busy_rise.size(), 2);
        chk("t3_b2b", qat(busy_rise, 1) - qat(busy_fall, 0), 10);
        chk("t3_len1", qat(busy_fall, 0) - qat(busy_rise, 0), 5260);
        chk("t3_len2", qat(busy_fall, 1) - qat(busy_rise, 1), 5480);

        // 5: async reset during START burst
        do_reset();
        wr(8'h92, 8'h02);
        wait_busy(1'b1, 100, "t5_start");
        repeat (200) @(negedge CLK);
        for (int n = 0; n < 20 && !IR_LED; n++) @(negedge CLK);
        pre = IR_LED;
        chk("t5_led_hi", int'(pre), 1);
        RESET = 1'b1;
        #1;
        chk("t5_led", int'(IR_LED), 0);
        chk("t5_busy", int'(BUSY), 0);
        repeat (3) @(negedge CLK);
        clear_logs();
        RESET = 1'b0;
        repeat (3000) @(negedge CLK);
        chk("t5_no_busy", busy_rise.size(), 0);
        chk("t5_no_led", led_rise.size(), 0);

        // 6: unmapped addresses are ignored
        do_reset();
        wr(8'h93, 8'h03);
        wr(8'h00, 8'h02);
        wr(8'h00, 8'h03);
        wr(8'h93, 8'h02);
        chk("t6_car", int'(CAR_SEL), 1);
        repeat (2500) @(negedge CLK);
        chk("t6_no_busy", busy_rise.size(), 0);
        chk("t6_no_led", led_rise.size(), 0);
        wr(8'h92, 8'h02);
        wait_busy(1'b1, 100, "t6_start");
        wait_busy(1'b0, 6000, "t6_end");
        repeat (100) @(negedge CLK);
        split();
        chk_pkt("t6", 0, e6, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
